// File: rtl/spi_tx_mlane.sv
// Multi-lane SPI transmit shifter with word FIFO: 1/2/4-lane output, MSB/LSB-first ordering,
// length-terminated transfers and underrun abort when the FIFO runs dry at a word boundary.
module spi_tx_mlane #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  logic                        tx_edge_i,
  input  logic [1:0]                  lane_mode_i,
  input  logic                        lsb_first_i,
  input  logic [LEN_W-1:0]            tx_len_i,
  input  logic                        tx_len_update_i,
  input  logic [DATA_W-1:0]           tx_data_i,
  input  logic                        tx_data_vld_i,
  output logic                        tx_data_rdy_o,
  output logic [3:0]                  sdo_o,
  output logic [3:0]                  sdo_oe_o,
  output logic                        tx_done_o,
  output logic                        underrun_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LVW = AW + 1;
  localparam int unsigned CW  = LEN_W + 1;
  localparam int unsigned WW  = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LVW-1:0]    level_q;
  logic              fifo_full, fifo_empty, push, pop;
  logic [LEN_W-1:0]  len_q, len_snap_q;
  logic [1:0]        mode_q;
  logic              lsb_q;
  logic [DATA_W-1:0] sreg_q;
  logic [CW-1:0]     bit_cnt_q;
  logic [WW-1:0]     word_cnt_q;
  logic [2:0]        lanes;
  logic              last_beat, word_end, start, shift_edge;

  assign fifo_full     = (level_q == LVW'(FIFO_DEPTH));
  assign fifo_empty    = (level_q == '0);
  assign tx_data_rdy_o = !fifo_full;
  assign push          = tx_data_vld_i && !fifo_full;
  assign fifo_level_o  = level_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (!push && pop) level_q <= level_q - 1'b1;
    end
  end

  // Storage needs no reset: the level counter alone defines validity.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= tx_data_i;
  end

  always_comb begin
    case (mode_q)
      2'd1:    lanes = 3'd2;
      2'd2:    lanes = 3'd4;
      default: lanes = 3'd1;
    endcase
  end

  assign last_beat  = (bit_cnt_q + CW'(lanes)) >= CW'(len_snap_q);
  assign word_end   = (word_cnt_q + WW'(lanes)) == WW'(DATA_W);
  assign start      = en_i && !fifo_empty && (len_q != '0);
  assign shift_edge = (state_q == StShift) && tx_edge_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  state_d = StShift;
      StShift: if (tx_edge_i && (last_beat || (word_end && fifo_empty))) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o     = (state_q != StIdle);
    tx_done_o  = shift_edge && last_beat;
    underrun_o = shift_edge && !last_beat && word_end && fifo_empty;
    pop        = (state_q == StLoad) || (shift_edge && !last_beat && word_end && !fifo_empty);
    sdo_o      = 4'h0;
    sdo_oe_o   = 4'h0;
    if (state_q == StShift) begin
      case (lanes)
        3'd4: begin
          sdo_oe_o = 4'hf;
          sdo_o    = lsb_q ? sreg_q[3:0] : sreg_q[DATA_W-1 -: 4];
        end
        3'd2: begin
          sdo_oe_o   = 4'h3;
          sdo_o[1:0] = lsb_q ? sreg_q[1:0] : sreg_q[DATA_W-1 -: 2];
        end
        default: begin
          sdo_oe_o = 4'h1;
          sdo_o[0] = lsb_q ? sreg_q[0] : sreg_q[DATA_W-1];
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      len_q      <= '0;
      len_snap_q <= '0;
      mode_q     <= '0;
      lsb_q      <= 1'b0;
      sreg_q     <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      if (tx_len_update_i) len_q <= tx_len_i;
      if (state_q == StIdle && start) begin
        len_snap_q <= len_q;
        mode_q     <= lane_mode_i;
        lsb_q      <= lsb_first_i;
      end
      if (state_q == StLoad) begin
        sreg_q     <= mem_q[rd_ptr_q];
        bit_cnt_q  <= '0;
        word_cnt_q <= '0;
      end else if (shift_edge) begin
        bit_cnt_q <= bit_cnt_q + CW'(lanes);
        // Word refill lands on the same edge so the next beat follows without a gap.
        if (pop) begin
          sreg_q     <= mem_q[rd_ptr_q];
          word_cnt_q <= '0;
        end else begin
          word_cnt_q <= word_cnt_q + WW'(lanes);
          sreg_q     <= lsb_q ? (sreg_q >> lanes) : (sreg_q << lanes);
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_tx_mlane.sv
// Self-checking bench for spi_tx_mlane: directed scenarios plus randomized transfers checked
// against a bit-stream model of the words pushed.
module tb_spi_tx_mlane;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en, tx_edge, lsb_first, tx_len_update, tx_data_vld;
  logic [1:0]    lane_mode;
  logic [LW-1:0] tx_len;
  logic [DW-1:0] tx_data;
  logic          tx_data_rdy, tx_done, underrun, busy;
  logic [3:0]    sdo, sdo_oe;
  logic [2:0]    fifo_level;

  spi_tx_mlane #(.DATA_W(DW), .LEN_W(LW), .FIFO_DEPTH(FD)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .tx_edge_i(tx_edge), .lane_mode_i(lane_mode),
    .lsb_first_i(lsb_first), .tx_len_i(tx_len), .tx_len_update_i(tx_len_update),
    .tx_data_i(tx_data), .tx_data_vld_i(tx_data_vld), .tx_data_rdy_o(tx_data_rdy),
    .sdo_o(sdo), .sdo_oe_o(sdo_oe), .tx_done_o(tx_done), .underrun_o(underrun),
    .busy_o(busy), .fifo_level_o(fifo_level)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] mw [4];
  int            m_l, m_len, m_nw;
  bit            m_lsb;
  logic [9:0]    obs [160];

  function automatic int lanes_of(input int mode);
    return (mode == 1) ? 2 : (mode == 2) ? 4 : 1;
  endfunction

  // Last beat index: either the length rounded up to whole beats, or the word boundary
  // where the pushed words run out, whichever comes first.
  function automatic int m_fin();
    return (m_len + m_l - 1) / m_l - 1;
  endfunction
  function automatic bit m_unr();
    return (m_nw * DW / m_l - 1) < m_fin();
  endfunction
  function automatic int m_end();
    return m_unr() ? (m_nw * DW / m_l - 1) : m_fin();
  endfunction
  function automatic int m_level_after();
    return m_unr() ? 0 : m_nw - ((m_end() + 1) * m_l + DW - 1) / DW;
  endfunction

  // Expected {sdo, oe, done, underrun} for beat k of the serialized word stream.
  function automatic logic [9:0] exp_vec(input int k);
    logic [3:0] v, oe;
    int e;
    v = 4'h0; oe = 4'h0; e = m_end();
    if (k <= e) begin
      oe = (m_l == 4) ? 4'hf : (m_l == 2) ? 4'h3 : 4'h1;
      for (int j = 0; j < m_l; j++) begin
        int i;
        i = k * m_l + (m_lsb ? j : m_l - 1 - j);
        if (i < m_nw * DW) v[j] = m_lsb ? mw[i / DW][i % DW] : mw[i / DW][DW - 1 - (i % DW)];
      end
    end
    return {v, oe, (k == e) && !m_unr(), (k == e) && m_unr()};
  endfunction

  function automatic logic [9:0] exp_mask(input int k);
    logic [9:0] m;
    m = 10'h03f;
    if (k <= m_end()) begin
      for (int j = 0; j < m_l; j++) begin
        if (k * m_l + (m_lsb ? j : m_l - 1 - j) < m_len) m[6 + j] = 1'b1;
      end
    end
    return m;
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; tx_edge = 1'b0; tx_data_vld = 1'b0; tx_len_update = 1'b0;
    #1; cyc(); cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic set_len(input int len);
    tx_len = LW'(len); tx_len_update = 1'b1;
    cyc();
    tx_len_update = 1'b0;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    tx_data = w; tx_data_vld = 1'b1;
    cyc();
    tx_data_vld = 1'b0;
  endtask

  task automatic load_xfer(input int mode, input bit lsb, input int len, input int nw);
    lane_mode = 2'(mode); lsb_first = lsb;
    set_len(len);
    for (int i = 0; i < nw; i++) push_word(mw[i]);
    m_l = lanes_of(mode); m_lsb = lsb; m_len = len; m_nw = nw;
  endtask

  task automatic start_xfer();
    int n;
    en = 1'b1; n = 0;
    while (sdo_oe == 4'h0 && n < 10) begin cyc(); n++; end
    en = 1'b0;
    total++;
    if (sdo_oe == 4'h0) begin
      bad++; $display("FAIL start: sdo_oe=%h required nonzero within 10 cycles", sdo_oe);
    end
  endtask

  task automatic run_beats(input int nb, input int gap);
    for (int k = 0; k < nb; k++) begin
      tx_edge = 1'b1;
      @(negedge clk);
      obs[k] = {sdo, sdo_oe, tx_done, underrun};
      cyc();
      tx_edge = 1'b0;
      repeat (gap) cyc();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; #1;
    total++;
    if ({sdo, sdo_oe, tx_done, underrun, busy, fifo_level} !== 13'h0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0",
                      {sdo, sdo_oe, tx_done, underrun, busy, fifo_level});
    end
    do_reset();
    total++;
    if (tx_data_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy: got %b want 1", tx_data_rdy); end
  endtask

  task automatic test_single_msb();
    do_reset();
    mw[0] = 32'ha500_0001;
    load_xfer(0, 1'b0, 32, 1);
    start_xfer();
    run_beats(33, 1);
    for (int k = 0; k < 33; k++) begin
      total++;
      if ((obs[k] & exp_mask(k)) !== (exp_vec(k) & exp_mask(k))) begin
        bad++; $display("FAIL single_beat%0d: got %h want %h", k, obs[k] & exp_mask(k),
                        exp_vec(k) & exp_mask(k));
      end
    end
    total++;
    if ({busy, fifo_level} !== 4'h0) begin
      bad++; $display("FAIL single_after: busy/level got %h want 0", {busy, fifo_level});
    end
  endtask

  task automatic test_quad_lsb();
    do_reset();
    mw[0] = 32'h8765_4321; mw[1] = 32'h0fed_cba9;
    load_xfer(2, 1'b1, 64, 2);
    start_xfer();
    run_beats(17, 0);
    for (int k = 0; k < 17; k++) begin
      total++;
      if ((obs[k] & exp_mask(k)) !== (exp_vec(k) & exp_mask(k))) begin
        bad++; $display("FAIL quad_beat%0d: got %h want %h", k, obs[k] & exp_mask(k),
                        exp_vec(k) & exp_mask(k));
      end
    end
    total++;
    if (fifo_level !== 3'd0) begin bad++; $display("FAIL quad_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_underrun();
    do_reset();
    mw[0] = $urandom;
    load_xfer(1, 1'b0, 64, 1);
    start_xfer();
    run_beats(16, 1);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL underrun_busy: got %b want 0", busy); end
    for (int k = 0; k < 16; k++) begin
      total++;
      if ((obs[k] & exp_mask(k)) !== (exp_vec(k) & exp_mask(k))) begin
        bad++; $display("FAIL underrun_beat%0d: got %h want %h", k, obs[k] & exp_mask(k),
                        exp_vec(k) & exp_mask(k));
      end
    end
  endtask

  task automatic test_non_multiple();
    do_reset();
    for (int i = 0; i < 3; i++) mw[i] = $urandom;
    load_xfer(2, 1'b0, 10, 3);
    start_xfer();
    run_beats(4, 1);
    for (int k = 0; k < 4; k++) begin
      total++;
      if ((obs[k] & exp_mask(k)) !== (exp_vec(k) & exp_mask(k))) begin
        bad++; $display("FAIL nonmult_beat%0d: got %h want %h", k, obs[k] & exp_mask(k),
                        exp_vec(k) & exp_mask(k));
      end
    end
    total++;
    if (fifo_level !== 3'd2) begin bad++; $display("FAIL nonmult_level: got %0d want 2", fifo_level); end
  endtask

  task automatic test_fifo_full();
    do_reset();
    for (int i = 0; i < 4; i++) mw[i] = $urandom;
    lane_mode = 2'd2; lsb_first = 1'b1;
    set_len(128);
    for (int i = 0; i < 4; i++) push_word(mw[i]);
    total++;
    if ({tx_data_rdy, fifo_level} !== 4'b0_100) begin
      bad++; $display("FAIL full_after4: rdy/level got %b want 0100", {tx_data_rdy, fifo_level});
    end
    tx_data = ~mw[0]; tx_data_vld = 1'b1;
    repeat (3) cyc();
    tx_data_vld = 1'b0;
    total++;
    if ({tx_data_rdy, fifo_level} !== 4'b0_100) begin
      bad++; $display("FAIL full_held: rdy/level got %b want 0100", {tx_data_rdy, fifo_level});
    end
    m_l = 4; m_lsb = 1'b1; m_len = 128; m_nw = 4;
    start_xfer();
    run_beats(33, 0);
    for (int k = 0; k < 33; k++) begin
      total++;
      if ((obs[k] & exp_mask(k)) !== (exp_vec(k) & exp_mask(k))) begin
        bad++; $display("FAIL full_drain_beat%0d: got %h want %h", k, obs[k] & exp_mask(k),
                        exp_vec(k) & exp_mask(k));
      end
    end
    total++;
    if (fifo_level !== 3'd0) begin bad++; $display("FAIL full_drained: got %0d want 0", fifo_level); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mw[0] = $urandom;
    load_xfer(0, 1'b0, 32, 1);
    start_xfer();
    run_beats(4, 1);
    tx_edge = 1'b1;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({sdo, sdo_oe, tx_done, underrun, busy, fifo_level} !== 13'h0) begin
      bad++; $display("FAIL rstmid_outputs: got %h want 0",
                      {sdo, sdo_oe, tx_done, underrun, busy, fifo_level});
    end
    tx_edge = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    total++;
    if ({tx_done, underrun, busy, fifo_level} !== 6'h0) begin
      bad++; $display("FAIL rstmid_after: got %h want 0", {tx_done, underrun, busy, fifo_level});
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if ((obs[k] & exp_mask(k)) !== (exp_vec(k) & exp_mask(k))) begin
        bad++; $display("FAIL rstmid_beat%0d: got %h want %h", k, obs[k] & exp_mask(k),
                        exp_vec(k) & exp_mask(k));
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int it = 0; it < 20; it++) begin
      int mode, len, l, nw, nb;
      bit lsb;
      mode = $urandom_range(0, 3); lsb = 1'($urandom); len = $urandom_range(1, 128);
      l = lanes_of(mode);
      nb = (len + l - 1) / l;
      nw = (nb * l + DW - 1) / DW;
      if (nw > 1 && $urandom_range(0, 3) == 0) nw = nw - 1;
      for (int i = 0; i < 4; i++) mw[i] = $urandom;
      load_xfer(mode, lsb, len, nw);
      start_xfer();
      // Configuration churn mid-transfer must not disturb the running transfer.
      lane_mode = 2'($urandom); lsb_first = 1'($urandom);
      set_len($urandom_range(0, 200));
      nb = m_end() + 2;
      run_beats(nb, $urandom_range(0, 2));
      for (int k = 0; k < nb; k++) begin
        total++;
        if ((obs[k] & exp_mask(k)) !== (exp_vec(k) & exp_mask(k))) begin
          bad++; $display("FAIL rand%0d_beat%0d: got %h want %h", it, k, obs[k] & exp_mask(k),
                          exp_vec(k) & exp_mask(k));
        end
      end
      total++;
      if ({busy, fifo_level} !== {1'b0, 3'(m_level_after())}) begin
        bad++; $display("FAIL rand%0d_after: busy/level got %h want %h", it, {busy, fifo_level},
                        {1'b0, 3'(m_level_after())});
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; tx_edge = 1'b0; lane_mode = 2'd0; lsb_first = 1'b0;
    tx_len = '0; tx_len_update = 1'b0; tx_data = '0; tx_data_vld = 1'b0;
    test_reset();
    test_single_msb();
    test_quad_lsb();
    test_underrun();
    test_non_multiple();
    test_fifo_full();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
